trig_counter_capture: RTL

Counter/capture stage between the TriggerIn endpoint and the WireOut/TriggerOut endpoints of the Controls design.
- Consumes one-cycle trigger pulses and a step value from a WireIn.
- Maintains a free-running counter and a stepped up/down counter.
- Produces coherent snapshots of both counters, so the host reads their 16-bit halves without tearing between reads.
- Emits one-cycle status pulses for a TriggerOut endpoint.

---
 rtl/trig_counter_capture_pkg.sv | 39 +++
 rtl/trig_counter_capture_if.sv | 27 ++
 rtl/trig_counter_capture_ud_accum.sv | 75 +++++++
 rtl/trig_counter_capture.sv | 108 ++++++++++
 4 files changed

// File: rtl/trig_counter_capture_pkg.sv
// Shared trigger/status bit positions and small helpers for the counter/capture stage.
// Both the top level and the bench import this package.
package trig_counter_pkg;

   localparam int TRIG_W = 16;

   localparam int TRIG_CLEAR   = 0;
   localparam int TRIG_UP      = 1;
   localparam int TRIG_DOWN    = 2;
   localparam int TRIG_CAPTURE = 3;

   localparam int TOUT_CAP_DONE = 0;
   localparam int TOUT_SAT      = 1;

   typedef struct packed {
      logic clear;
      logic up;
      logic down;
      logic capture;
   } trig_cmd_t;

   function automatic trig_cmd_t decodeTrig(input logic [3:0] trigLow);
      trig_cmd_t cmd;
      cmd.clear   = trigLow[TRIG_CLEAR];
      cmd.up      = trigLow[TRIG_UP];
      cmd.down    = trigLow[TRIG_DOWN];
      cmd.capture = trigLow[TRIG_CAPTURE];
      return cmd;
   endfunction

   function automatic logic [TRIG_W-1:0] packTrigOut(input logic capDone, input logic sat);
      logic [TRIG_W-1:0] word;
      word                = '0;
      word[TOUT_CAP_DONE] = capDone;
      word[TOUT_SAT]      = sat;
      return word;
   endfunction

endpackage

// File: rtl/trig_counter_capture_if.sv
// Host-facing bundle: trigger/WireIn inputs towards the counter stage and
// the live counters, snapshots and status pulses coming back.
interface trig_counter_capture_if #(
   parameter int WIDTH  = 32,
   parameter int STEP_W = 16
);
   logic [15:0]       trig;
   logic [STEP_W-1:0] step;
   logic              sat_mode;
   logic [WIDTH-1:0]  free_cnt;
   logic [WIDTH-1:0]  ud_cnt;
   logic [WIDTH-1:0]  snap_free;
   logic [WIDTH-1:0]  snap_ud;
   logic [7:0]        snap_seq;
   logic              sat_flag;
   logic [15:0]       trig_out;

   modport master (
      output trig, step, sat_mode,
      input  free_cnt, ud_cnt, snap_free, snap_ud, snap_seq, sat_flag, trig_out
   );

   modport slave (
      input  trig, step, sat_mode,
      output free_cnt, ud_cnt, snap_free, snap_ud, snap_seq, sat_flag, trig_out
   );
endinterface

// File: rtl/trig_counter_capture_ud_accum.sv
// Up/down accumulator with wrap or saturate arithmetic; reports each clamp as a
// one-cycle strobe and keeps a sticky saturation flag that only clear resets.
module ud_accum #(
   parameter int WIDTH  = 32,
   parameter int STEP_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              up_i,
   input  logic              down_i,
   input  logic [STEP_W-1:0] step_i,
   input  logic              satMode_i,
   output logic [WIDTH-1:0]  value_o,
   output logic              clamp_o,
   output logic              satFlag_o
);

   localparam int EXT_W = WIDTH + 1;

   logic [WIDTH-1:0] value_q, value_d;
   logic             clamp_q, clamp_d;
   logic             satFlag_q, satFlag_d;
   logic [EXT_W-1:0] stepExt, sum, diff;

   // The extra top bit of sum/diff is the carry/borrow; an exact landing on
   // all-ones or zero leaves it clear, so it never counts as a clamp.
   always_comb begin
      stepExt   = EXT_W'(step_i);
      sum       = {1'b0, value_q} + stepExt;
      diff      = {1'b0, value_q} - stepExt;
      value_d   = value_q;
      clamp_d   = 1'b0;
      satFlag_d = satFlag_q;
      if (clear_i) begin
         value_d   = '0;
         satFlag_d = 1'b0;
      end else if (up_i && down_i) begin
         value_d = value_q;
      end else if (up_i) begin
         if (sum[WIDTH] && satMode_i) begin
            value_d   = '1;
            clamp_d   = 1'b1;
            satFlag_d = 1'b1;
         end else begin
            value_d = sum[WIDTH-1:0];
         end
      end else if (down_i) begin
         if (diff[WIDTH] && satMode_i) begin
            value_d   = '0;
            clamp_d   = 1'b1;
            satFlag_d = 1'b1;
         end else begin
            value_d = diff[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         value_q   <= '0;
         clamp_q   <= 1'b0;
         satFlag_q <= 1'b0;
      end else begin
         value_q   <= value_d;
         clamp_q   <= clamp_d;
         satFlag_q <= satFlag_d;
      end
   end

   assign value_o   = value_q;
   assign clamp_o   = clamp_q;
   assign satFlag_o = satFlag_q;

endmodule

// File: rtl/trig_counter_capture.sv
// Counter/capture stage: free-running and stepped counters, tear-free snapshots
// for the host, and one-cycle TriggerOut status pulses.
module trig_counter_capture
   import trig_counter_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STEP_W = 16
) (
   input  logic                   sys_clk,
   input  logic                   reset_n,
   trig_counter_capture_if.slave  bus
);

   logic [1:0]        rstSync_q;
   logic              rstN;
   logic [STEP_W-1:0] stepMeta_q, step_q;
   logic              modeMeta_q, mode_q;
   logic [WIDTH-1:0]  freeCnt_q, freeCnt_d;
   logic [WIDTH-1:0]  snapFree_q, snapFree_d;
   logic [WIDTH-1:0]  snapUd_q, snapUd_d;
   logic [7:0]        snapSeq_q, snapSeq_d;
   logic              capDone_q, capDone_d;
   logic [WIDTH-1:0]  udValue;
   logic              udClamp;
   logic              udSatFlag;
   trig_cmd_t         cmd;
   logic              unusedTrig;

   // Reset asserts immediately but releases two edges later, clean of sys_clk.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         rstSync_q <= '0;
      end else begin
         rstSync_q <= {rstSync_q[0], 1'b1};
      end
   end

   assign rstN       = rstSync_q[1];
   assign cmd        = decodeTrig(bus.trig[3:0]);
   assign unusedTrig = ^bus.trig[TRIG_W-1:4];

   // step and sat_mode come from the ti_clk WireIn side, so only the
   // second synchronizer stage feeds the arithmetic.
   always_ff @(posedge sys_clk or negedge rstN) begin
      if (!rstN) begin
         stepMeta_q <= '0;
         step_q     <= '0;
         modeMeta_q <= 1'b0;
         mode_q     <= 1'b0;
      end else begin
         stepMeta_q <= bus.step;
         step_q     <= stepMeta_q;
         modeMeta_q <= bus.sat_mode;
         mode_q     <= modeMeta_q;
      end
   end

   // Snapshots take the pre-update counter values, so a capture issued with
   // clear still records the old up/down count.
   always_comb begin
      freeCnt_d  = freeCnt_q + WIDTH'(1);
      snapFree_d = cmd.capture ? freeCnt_q : snapFree_q;
      snapUd_d   = cmd.capture ? udValue : snapUd_q;
      snapSeq_d  = snapSeq_q + 8'(cmd.capture);
      capDone_d  = cmd.capture;
   end

   always_ff @(posedge sys_clk or negedge rstN) begin
      if (!rstN) begin
         freeCnt_q  <= '0;
         snapFree_q <= '0;
         snapUd_q   <= '0;
         snapSeq_q  <= '0;
         capDone_q  <= 1'b0;
      end else begin
         freeCnt_q  <= freeCnt_d;
         snapFree_q <= snapFree_d;
         snapUd_q   <= snapUd_d;
         snapSeq_q  <= snapSeq_d;
         capDone_q  <= capDone_d;
      end
   end

   ud_accum #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W)
   ) u_udAccum (
      .clk_i     (sys_clk),
      .rst_ni    (rstN),
      .clear_i   (cmd.clear),
      .up_i      (cmd.up),
      .down_i    (cmd.down),
      .step_i    (step_q),
      .satMode_i (mode_q),
      .value_o   (udValue),
      .clamp_o   (udClamp),
      .satFlag_o (udSatFlag)
   );

   assign bus.free_cnt  = freeCnt_q;
   assign bus.ud_cnt    = udValue;
   assign bus.snap_free = snapFree_q;
   assign bus.snap_ud   = snapUd_q;
   assign bus.snap_seq  = snapSeq_q;
   assign bus.sat_flag  = udSatFlag;
   assign bus.trig_out  = packTrigOut(capDone_q, udClamp);

endmodule
